// File: rtl/dut_pair_driver.sv
// Drives four 2-bit input pairs onto an external DUT in turn, holds each for
// SETTLE_CYCLES clocks, samples the synchronized DUT response at the end of
// each hold and presents the 4-bit result through a valid/ready handshake.
module dut_pair_driver #(
    parameter int unsigned SETTLE_CYCLES = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_byte,
    output logic       in_ready,
    input  logic       dut_out,
    output logic [1:0] dut_pinout,
    output logic       out_valid,
    output logic [7:0] out_byte,
    input  logic       out_ready,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        DONE
    } state_t;

    localparam logic [15:0] LAST_COUNT = 16'(SETTLE_CYCLES - 1);

    state_t      state_q, state_d;
    logic [7:0]  byte_q, byte_d;
    logic [1:0]  pair_q, pair_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  result_q, result_d;
    logic [1:0]  pinout_q, pinout_d;
    logic [7:0]  out_byte_q, out_byte_d;
    logic        out_valid_q, out_valid_d;
    logic        sync1_q, sync1_d;
    logic        sync2_q, sync2_d;

    // Next-state logic: accept a byte, walk the four pairs, then hold the result.
    always_comb begin
        state_d     = state_q;
        byte_d      = byte_q;
        pair_d      = pair_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        pinout_d    = pinout_q;
        out_byte_d  = out_byte_q;
        out_valid_d = out_valid_q;
        sync1_d     = dut_out;
        sync2_d     = sync1_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    byte_d   = in_byte;
                    pair_d   = '0;
                    pinout_d = in_byte[1:0];
                    cnt_d    = '0;
                    result_d = '0;
                    state_d  = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q == LAST_COUNT) begin
                    result_d[pair_q] = sync2_q;
                    cnt_d            = '0;
                    if (pair_q == 2'd3) begin
                        out_byte_d  = {4'b0000, result_d};
                        out_valid_d = 1'b1;
                        pinout_d    = '0;
                        state_d     = DONE;
                    end else begin
                        pair_d   = pair_q + 2'd1;
                        pinout_d = 2'(byte_q >> {pair_d, 1'b0});
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously so a run aborts at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            byte_q      <= '0;
            pair_q      <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            pinout_q    <= '0;
            out_byte_q  <= '0;
            out_valid_q <= 1'b0;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_q      <= byte_d;
            pair_q      <= pair_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            pinout_q    <= pinout_d;
            out_byte_q  <= out_byte_d;
            out_valid_q <= out_valid_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign dut_pinout = pinout_q;
    assign out_valid  = out_valid_q;
    assign out_byte   = out_byte_q;

endmodule

// File: tb/tb_dut_pair_driver.sv
// Bench for dut_pair_driver with SETTLE_CYCLES = 4 and a selectable gate
// (AND / XOR / OR) standing in for the external DUT.
module tb_dut_pair_driver;

    localparam int SC = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_byte;
    logic       in_ready;
    logic       dut_out;
    logic [1:0] dut_pinout;
    logic       out_valid;
    logic [7:0] out_byte;
    logic       out_ready;
    logic       busy;

    int gate_sel = 0;   // 0 = AND, 1 = XOR, 2 = OR
    int total = 0;
    int bad = 0;

    dut_pair_driver #(.SETTLE_CYCLES(SC)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_byte    (in_byte),
        .in_ready   (in_ready),
        .dut_out    (dut_out),
        .dut_pinout (dut_pinout),
        .out_valid  (out_valid),
        .out_byte   (out_byte),
        .out_ready  (out_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic gate(input logic a, input logic b, input int sel);
        case (sel)
            0:       return a & b;
            1:       return a ^ b;
            default: return a | b;
        endcase
    endfunction

    // External DUT: combinational gate on the driven pair.
    assign dut_out = gate(dut_pinout[1], dut_pinout[0], gate_sel);

    function automatic logic [1:0] pair_bits(input logic [7:0] b, input int k);
        logic [7:0] t;
        t = b >> (2 * k);
        return t[1:0];
    endfunction

    function automatic logic [3:0] gate_result(input logic [7:0] b, input int sel);
        logic [3:0] r;
        logic [1:0] p;
        for (int k = 0; k < 4; k++) begin
            p    = pair_bits(b, k);
            r[k] = gate(p[1], p[0], sel);
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: elapsed cycles since accept decide the pair on the pins.
    logic       m_run = 1'b0;
    logic       m_done = 1'b0;
    int         m_elapsed = 0;
    logic [7:0] m_byte = '0;
    logic [3:0] m_res = '0;
    logic [7:0] m_out_byte = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_run      <= 1'b0;
            m_done     <= 1'b0;
            m_elapsed  <= 0;
            m_byte     <= '0;
            m_res      <= '0;
            m_out_byte <= '0;
        end else if (!m_run && !m_done) begin
            if (in_valid) begin
                m_run     <= 1'b1;
                m_elapsed <= 0;
                m_byte    <= in_byte;
                m_res     <= gate_result(in_byte, gate_sel);
            end
        end else if (m_run) begin
            if (m_elapsed == 4 * SC - 1) begin
                m_run      <= 1'b0;
                m_done     <= 1'b1;
                m_out_byte <= {4'h0, m_res};
            end else begin
                m_elapsed <= m_elapsed + 1;
            end
        end else if (out_ready) begin
            m_done <= 1'b0;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (!rst) begin
            check("in_ready", 32'(in_ready), 32'(!(m_run || m_done)));
            check("busy", 32'(busy), 32'(m_run || m_done));
            check("pinout", 32'(dut_pinout), m_run ? 32'(pair_bits(m_byte, m_elapsed / SC)) : 32'd0);
            check("out_valid", 32'(out_valid), 32'(m_done));
            if (m_done) check("out_byte", 32'(out_byte), 32'(m_out_byte));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out(input int limit);
        int n;
        n = 0;
        while (!out_valid && n < limit) begin
            tick();
            n++;
        end
        if (!out_valid) begin
            total++;
            bad++;
            $display("FAIL wait_out_valid actual=timeout required=out_valid within %0d cycles", limit);
        end
    endtask

    initial begin
        int n;
        logic [31:0] seq;
        logic seen;

        rst = 1'b1;
        in_valid = 1'b0;
        in_byte = '0;
        out_ready = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_pinout", 32'(dut_pinout), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_byte", 32'(out_byte), 32'h00);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        tick();

        // AND gate: pin sequence, latency, result
        gate_sel = 0;
        in_valid = 1'b1;
        in_byte = 8'hE4;
        tick();
        in_valid = 1'b0;
        seq = '0;
        n = 0;
        while (!out_valid && n < 64) begin
            if (n < 16) seq[2*n +: 2] = dut_pinout;
            tick();
            n++;
        end
        check("and_latency", 32'(n), 32'd16);
        check("and_pin_seq", seq, 32'hFFAA5500);
        check("and_out_byte", 32'(out_byte), 32'h08);

        // Backpressure: result holds, offered byte is ignored
        in_valid = 1'b1;
        in_byte = 8'h55;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_hold", {22'd0, out_valid, in_ready, out_byte}, {22'd0, 1'b1, 1'b0, 8'h08});
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_release", {30'd0, out_valid, in_ready}, 32'b01);

        // XOR gate with out_ready tied high
        gate_sel = 1;
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_byte = 8'hE4;
        tick();
        in_valid = 1'b0;
        wait_out(64);
        check("xor_out_byte", 32'(out_byte), 32'h06);
        tick();
        check("xor_one_cycle", {30'd0, out_valid, in_ready}, 32'b01);
        out_ready = 1'b0;

        // Reset pulse during pair 2 aborts the run
        gate_sel = 0;
        in_valid = 1'b1;
        in_byte = 8'hE4;
        tick();
        in_valid = 1'b0;
        repeat (9) tick();
        check("pair2_pinout", 32'(dut_pinout), 32'b10);
        #2 rst = 1'b1;
        #1;
        check("abort_pinout", 32'(dut_pinout), 32'd0);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        tick();
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 24; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        check("no_out_after_abort", 32'(seen), 32'd0);

        // Accept on the first edge after reset release
        #2 rst = 1'b1;
        tick();
        rst = 1'b0;
        in_valid = 1'b1;
        in_byte = 8'hE4;
        tick();
        in_valid = 1'b0;
        check("accept_after_rst", 32'(busy), 32'd1);
        wait_out(64);
        check("post_rst_out_byte", 32'(out_byte), 32'h08);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Back-to-back with OR gate
        gate_sel = 2;
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_byte = 8'hE4;
        tick();
        in_byte = 8'h1B;
        wait_out(64);
        check("b2b_first", 32'(out_byte), 32'h0E);
        tick();
        check("b2b_idle_after_hs", 32'(in_ready), 32'd1);
        tick();
        check("b2b_second_accept", 32'(busy), 32'd1);
        in_valid = 1'b0;
        wait_out(64);
        check("b2b_second", 32'(out_byte), 32'h07);
        tick();
        out_ready = 1'b0;
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
